rf_writeback_arbiter: RTL and testbench
=======================================

Name: rf_writeback_arbiter

Overview:
- Owns the single write port of the 32x32 integer register file.
- Arbitrates between two writeback requesters: the single-cycle execute path (EX) and the multi-cycle load unit (LD).
- Keeps a pending-load scoreboard so decode can stall on RAW/WAW hazards against loads still in flight.
- Drives the register file write port from a registered stage, so accepted writes land one cycle after acceptance.

Parameters:
- DATA_W, 32, width of write data.
- NREGS, 32, number of architectural registers.
- IDX_W, 5, register index width; must satisfy 2**IDX_W == NREGS.

Ports:
- clk  input  1  clock, rising edge.
- nRST  input  1  asynchronous, active-low reset.
- ex_valid  input  1  EX writeback request.
- ex_ready  output  1  EX request accepted this cycle.
- ex_rd  input  IDX_W  EX destination index.
- ex_data  input  DATA_W  EX result.
- ld_valid  input  1  LD writeback request.
- ld_ready  output  1  LD request accepted this cycle.
- ld_rd  input  IDX_W  LD destination index.
- ld_data  input  DATA_W  LD data.
- ld_issue  input  1  load issued this cycle; marks ld_issue_rd pending.
- ld_issue_rd  input  IDX_W  destination of the issued load.
- chk_rs1  input  IDX_W  decode source index 1.
- chk_rs2  input  IDX_W  decode source index 2.
- chk_rd  input  IDX_W  decode destination index.
- hazard  output  1  any checked index is pending.
- busy  output  NREGS  pending-load scoreboard vector.
- rf_reg_write  output  1  register file write enable.
- rf_write_index  output  IDX_W  register file write index.
- rf_write_data  output  DATA_W  register file write data.
- rd_data1_in  input  DATA_W  register file read_data1 (bypass path only).
- rd_data2_in  input  DATA_W  register file read_data2 (bypass path only).
- rd_data1  output  DATA_W  read data 1 delivered to decode.
- rd_data2  output  DATA_W  read data 2 delivered to decode.

Behaviour:
- Reset (async, nRST low):
  - rf_reg_write=0, rf_write_index=0, rf_write_data=0.
  - busy=0.
  - Round-robin pointer rr=0 (EX preferred first).
- Arbitration (combinational grant, one grant per cycle):
  - Only one valid: that requester is granted.
  - Both valid: rr=0 grants EX, rr=1 grants LD.
  - rr updates on the clock edge after a conflict to point at the loser. It is unchanged on non-conflict cycles.
  - ex_ready = grant_ex; ld_ready = grant_ld. Both are 0 when the corresponding valid is 0.
  - A requester that is not granted holds valid, rd and data stable until ready.
- Write stage (1-cycle latency):
  - The grant at edge N produces rf_reg_write=1 with the winner's rd/data during cycle N+1.
  - With no grant, rf_reg_write=0 in the next cycle. Index and data hold their previous values.
- x0 rule:
  - A request with rd==0 is accepted normally (ready=1) but produces rf_reg_write=0.
  - busy[0] is never set; ld_issue with rd 0 is ignored.
- Scoreboard:
  - ld_issue sets busy[ld_issue_rd] at the edge.
  - An accepted LD writeback clears busy[ld_rd] at the same edge it is accepted.
  - Simultaneous set and clear of the same index: set wins.
  - An EX writeback never touches busy.
  - An LD writeback to a non-busy index is still written; busy stays 0.
- Hazard:
  - hazard = busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd]. Purely combinational from the current busy value.
- Reset mid-operation:
  - Pending scoreboard bits and any registered write are discarded.
  - No write issues after nRST rises until a new grant occurs.
- rd_data1/rd_data2 pass rd_data*_in through unchanged unless RF_BYPASS_EN is defined.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined:
  - If rf_reg_write=1 and rf_write_index equals the read index, the write-stage data is forwarded combinationally to rd_data1/rd_data2.
  - Adds inputs rd_index1 and rd_index2 (IDX_W each).
  - Index 0 is never forwarded.
- Undefined: pure pass-through; the rd_index ports are absent.

Test Plan:
- Reset, then ex_valid=1, ex_rd=5, ex_data=0xDEADBEEF for one cycle -> ex_ready=1 that cycle; next cycle rf_reg_write=1, index 5, data 0xDEADBEEF; following cycle rf_reg_write=0.
- ex_valid and ld_valid both held high for 4 cycles (ex_rd=1, ld_rd=2) -> grants alternate EX, LD, EX, LD; write port shows indices 1, 2, 1, 2 on successive cycles.
- ld_issue rd=7, then chk_rs2=7 -> busy[7]=1 and hazard=1. LD writeback rd=7 accepted -> busy[7]=0 at that edge; hazard=0 the next cycle.
- Same-cycle ld_issue rd=9 and accepted LD writeback rd=9 (busy[9] already 1) -> busy[9] remains 1.
- ex_valid with rd=0, data=0x1234 -> ex_ready=1, rf_reg_write stays 0. ld_issue rd=0 -> busy stays 0.
- Reset mid-operation: busy[3] set and a write pending, then nRST pulsed low mid-cycle -> outputs clear immediately and busy=0. With RF_BYPASS_EN: a write to index 4 with rd_index1=4 -> rd_data1 equals the write data, not rd_data1_in.

Source files
------------

// File: rtl/rf_writeback_arbiter.sv
// Writeback arbiter for the single register file write port: EX/LD round-robin
// arbitration, registered write stage, and pending-load scoreboard.
// Optional forwarding of the write stage onto the read ports when RF_BYPASS_EN is defined.
module rf_writeback_arbiter #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int IDX_W  = 5   // 2**IDX_W must equal NREGS
) (
  input  logic              clk,
  input  logic              nRST,
  // Handshake: a request is transferred on a rising edge where valid && ready;
  // ready is a combinational grant and a requester holds valid/rd/data until ready.
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [IDX_W-1:0]  ex_rd,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [IDX_W-1:0]  ld_rd,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_issue,
  input  logic [IDX_W-1:0]  ld_issue_rd,
  input  logic [IDX_W-1:0]  chk_rs1,
  input  logic [IDX_W-1:0]  chk_rs2,
  input  logic [IDX_W-1:0]  chk_rd,
  output logic              hazard,
  output logic [NREGS-1:0]  busy,
  output logic              rf_reg_write,
  output logic [IDX_W-1:0]  rf_write_index,
  output logic [DATA_W-1:0] rf_write_data,
`ifdef RF_BYPASS_EN
  input  logic [IDX_W-1:0]  rd_index1,
  input  logic [IDX_W-1:0]  rd_index2,
`endif
  input  logic [DATA_W-1:0] rd_data1_in,
  input  logic [DATA_W-1:0] rd_data2_in,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2
);

  logic              rr;
  logic              grant_ex;
  logic              grant_ld;
  logic              conflict;
  logic [NREGS-1:0]  busy_next;
  logic              win_write;
  logic [IDX_W-1:0]  win_rd;
  logic [DATA_W-1:0] win_data;

  // rr=0 prefers EX, rr=1 prefers LD when both request.
  always_comb begin
    conflict = ex_valid & ld_valid;
    grant_ex = ex_valid & (~ld_valid | ~rr);
    grant_ld = ld_valid & (~ex_valid | rr);
  end

  assign ex_ready = grant_ex;
  assign ld_ready = grant_ld;

  always_comb begin
    win_rd   = '0;
    win_data = '0;
    if (grant_ex) begin
      win_rd   = ex_rd;
      win_data = ex_data;
    end else if (grant_ld) begin
      win_rd   = ld_rd;
      win_data = ld_data;
    end
    // Writes to x0 are accepted but never reach the register file.
    win_write = (grant_ex | grant_ld) && (win_rd != '0);
  end

  // Clear on accepted LD writeback first so a same-edge issue to that index wins.
  always_comb begin
    busy_next = busy;
    if (grant_ld)
      busy_next[ld_rd] = 1'b0;
    if (ld_issue && (ld_issue_rd != '0))
      busy_next[ld_issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      rr             <= 1'b0;
      busy           <= '0;
      rf_reg_write   <= 1'b0;
      rf_write_index <= '0;
      rf_write_data  <= '0;
    end else begin
      // After a conflict the pointer moves to the loser.
      if (conflict)
        rr <= grant_ex;
      busy         <= busy_next;
      rf_reg_write <= win_write;
      if (grant_ex | grant_ld) begin
        rf_write_index <= win_rd;
        rf_write_data  <= win_data;
      end
    end
  end

  assign hazard = busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd];

`ifdef RF_BYPASS_EN
  // rf_reg_write is never set for x0, so index 0 is never forwarded.
  always_comb begin
    rd_data1 = rd_data1_in;
    rd_data2 = rd_data2_in;
    if (rf_reg_write && (rf_write_index == rd_index1) && (rd_index1 != '0))
      rd_data1 = rf_write_data;
    if (rf_reg_write && (rf_write_index == rd_index2) && (rd_index2 != '0))
      rd_data2 = rf_write_data;
  end
`else
  assign rd_data1 = rd_data1_in;
  assign rd_data2 = rd_data2_in;
`endif

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed bench for rf_writeback_arbiter: expected register file writes go through
// a queue checked by a negedge monitor; handshake/scoreboard outputs are checked inline.
module tb_rf_writeback_arbiter;
  localparam int DATA_W = 32;
  localparam int NREGS  = 32;
  localparam int IDX_W  = 5;
  localparam int EW     = IDX_W + DATA_W;

  logic              clk;
  logic              nRST;
  logic              ex_valid, ld_valid, ld_issue;
  logic              ex_ready, ld_ready, hazard;
  logic [IDX_W-1:0]  ex_rd, ld_rd, ld_issue_rd, chk_rs1, chk_rs2, chk_rd;
  logic [DATA_W-1:0] ex_data, ld_data;
  logic [NREGS-1:0]  busy;
  logic              rf_reg_write;
  logic [IDX_W-1:0]  rf_write_index;
  logic [DATA_W-1:0] rf_write_data;
  logic [IDX_W-1:0]  rd_index1, rd_index2;
  logic [DATA_W-1:0] rd_data1_in, rd_data2_in, rd_data1, rd_data2;

  logic [EW-1:0] exp_q[$];
  int n_checks;
  int n_errors;

  rf_writeback_arbiter #(.DATA_W(DATA_W), .NREGS(NREGS), .IDX_W(IDX_W)) dut (
    .clk(clk), .nRST(nRST),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_data(ex_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
    .hazard(hazard), .busy(busy),
    .rf_reg_write(rf_reg_write), .rf_write_index(rf_write_index), .rf_write_data(rf_write_data),
`ifdef RF_BYPASS_EN
    .rd_index1(rd_index1), .rd_index2(rd_index2),
`endif
    .rd_data1_in(rd_data1_in), .rd_data2_in(rd_data2_in),
    .rd_data1(rd_data1), .rd_data2(rd_data2)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: every write presented on the port must match the head of exp_q.
  always @(negedge clk) begin
    if (nRST === 1'b1 && rf_reg_write === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL rf_write_unexpected: got idx=%0d data=0x%0h expected no write",
                 rf_write_index, rf_write_data);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        if ({rf_write_index, rf_write_data} !== e) begin
          n_errors++;
          $display("FAIL rf_write: got idx=%0d data=0x%0h expected idx=%0d data=0x%0h",
                   rf_write_index, rf_write_data, e[EW-1:DATA_W], e[DATA_W-1:0]);
        end
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid = 1'b0; ld_valid = 1'b0; ld_issue = 1'b0;
  endtask

  task automatic expect_write(input logic [IDX_W-1:0] idx, input logic [DATA_W-1:0] data);
    exp_q.push_back({idx, data});
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    nRST = 1'b0;
    idle();
    ex_rd = '0; ex_data = '0; ld_rd = '0; ld_data = '0; ld_issue_rd = '0;
    chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
    rd_index1 = '0; rd_index2 = '0;
    rd_data1_in = 32'h0BAD_0001; rd_data2_in = 32'h0BAD_0002;
    repeat (2) @(posedge clk);
    #1;
    check("reset_we", rf_reg_write, 0);
    check("reset_idx", rf_write_index, 0);
    check("reset_data", rf_write_data, 0);
    check("reset_busy", busy, 0);
    nRST = 1'b1;
    step();
    check("idle_ex_ready", ex_ready, 0);
    check("idle_hazard", hazard, 0);

    // Single EX write, 1-cycle latency
    ex_valid = 1'b1; ex_rd = 5'd5; ex_data = 32'hDEADBEEF;
    #1 check("ex_single_ready", ex_ready, 1);
    check("ex_single_ld_ready", ld_ready, 0);
    expect_write(5'd5, 32'hDEADBEEF);
    step();
    ex_valid = 1'b0;
    check("ex_single_we", rf_reg_write, 1);
    step();
    check("ex_single_we_off", rf_reg_write, 0);
    check("ex_single_idx_hold", rf_write_index, 5);

    // Round-robin under sustained conflict: EX, LD, EX, LD
    ex_valid = 1'b1; ex_rd = 5'd1; ex_data = 32'h1111_1111;
    ld_valid = 1'b1; ld_rd = 5'd2; ld_data = 32'h2222_2222;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_ex_ready", ex_ready, (i % 2 == 0) ? 1 : 0);
      check("rr_ld_ready", ld_ready, (i % 2 == 1) ? 1 : 0);
      if (i % 2 == 0) expect_write(5'd1, 32'h1111_1111);
      else            expect_write(5'd2, 32'h2222_2222);
      step();
    end
    idle();
    check("rr_ld_nonbusy_busy", busy, 0);

    // Scoreboard set/clear and hazard
    ld_issue = 1'b1; ld_issue_rd = 5'd7;
    step();
    ld_issue = 1'b0;
    chk_rs2 = 5'd7;
    #1 check("sb_busy7", busy, 32'h0000_0080);
    check("sb_hazard_rs2", hazard, 1);
    chk_rs2 = 5'd6; chk_rs1 = 5'd7;
    #1 check("sb_hazard_rs1", hazard, 1);
    chk_rs1 = 5'd0; chk_rs2 = 5'd7;
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h0000_0077;
    #1 check("sb_ld_ready", ld_ready, 1);
    expect_write(5'd7, 32'h0000_0077);
    step();
    idle();
    check("sb_busy7_clear", busy, 0);
    check("sb_hazard_clear", hazard, 0);

    // Same-edge issue and writeback to an already-busy index: set wins
    ld_issue = 1'b1; ld_issue_rd = 5'd9;
    step();
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h0000_0099;
    expect_write(5'd9, 32'h0000_0099);
    step();
    idle();
    chk_rs2 = 5'd0; chk_rd = 5'd9;
    #1 check("sb_setwins_busy", busy, 32'h0000_0200);
    check("sb_setwins_hazard_rd", hazard, 1);
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h0000_0999;
    expect_write(5'd9, 32'h0000_0999);
    step();
    idle();
    check("sb_9_clear", busy, 0);
    chk_rd = 5'd0;

    // EX to a busy index must not clear it
    ld_issue = 1'b1; ld_issue_rd = 5'd12;
    step();
    ld_issue = 1'b0;
    ex_valid = 1'b1; ex_rd = 5'd12; ex_data = 32'h0000_0C0C;
    expect_write(5'd12, 32'h0000_0C0C);
    step();
    idle();
    check("ex_keeps_busy", busy, 32'h0000_1000);
    ld_valid = 1'b1; ld_rd = 5'd12; ld_data = 32'h0000_1212;
    expect_write(5'd12, 32'h0000_1212);
    step();
    idle();

    // x0: accepted but not written; issue to x0 ignored
    ex_valid = 1'b1; ex_rd = 5'd0; ex_data = 32'h0000_1234;
    #1 check("x0_ex_ready", ex_ready, 1);
    step();
    idle();
    check("x0_no_write", rf_reg_write, 0);
    ld_issue = 1'b1; ld_issue_rd = 5'd0;
    step();
    ld_issue = 1'b0;
    check("x0_busy", busy, 0);

    // Reset mid-operation discards busy and the registered write
    ld_issue = 1'b1; ld_issue_rd = 5'd3;
    step();
    ld_issue = 1'b0;
    ex_valid = 1'b1; ex_rd = 5'd10; ex_data = 32'hA5A5_A5A5;
    step();
    idle();
    check("rst_pre_we", rf_reg_write, 1);
    check("rst_pre_busy", busy, 32'h0000_0008);
    nRST = 1'b0;
    #1;
    check("rst_mid_we", rf_reg_write, 0);
    check("rst_mid_idx", rf_write_index, 0);
    check("rst_mid_data", rf_write_data, 0);
    check("rst_mid_busy", busy, 0);
    nRST = 1'b1;
    step();
    check("rst_post_we", rf_reg_write, 0);

    // Read path: forwarding when enabled, pass-through otherwise
    ex_valid = 1'b1; ex_rd = 5'd4; ex_data = 32'hCAFE_F00D;
    expect_write(5'd4, 32'hCAFE_F00D);
    rd_index1 = 5'd4; rd_index2 = 5'd5;
    step();
    idle();
`ifdef RF_BYPASS_EN
    check("bypass_rd1", rd_data1, 32'hCAFE_F00D);
`else
    check("pass_rd1", rd_data1, 32'h0BAD_0001);
`endif
    check("pass_rd2", rd_data2, 32'h0BAD_0002);

    step();
    step();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL missing_writes: got %0d outstanding expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
